bram_vector_writer: RTL

Write-side counterpart of the per-layer BRAM loaders. Snapshots a flat packed vector of `TOTAL_WEIGHTS` W-bit elements and streams it into BRAM one element per cycle, starting at `BASE_ADDR`, with a grant input so an external port arbiter can pause it. It drives the BRAM port signals directly, so the top level can mux it with the loaders onto one shared BRAM instance. Used to store layer activations or updated biases and weights back into memory.

---
 rtl/bram_vector_writer_pkg.sv | 20 ++
 rtl/bram_vector_writer.sv | 115 +++++++++++
 2 files changed

// File: rtl/bram_vector_writer_pkg.sv
// Shared BRAM-side definitions for the layer loaders and the vector writer.
package bram_vector_writer_pkg;

  // State encodings shared by the loader and writer FSMs.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Geometry of the single shared BRAM instance.
  localparam int unsigned BRAM_DATA_W = 8;
  localparam int unsigned BRAM_ADDR_W = 15;

  // Layer region base addresses, so that writer and loaders agree on the map.
  localparam int unsigned L1_WEIGHT_BASE = 0;
  localparam int unsigned L1_BIAS_BASE   = 16384;
  localparam int unsigned L2_WEIGHT_BASE = 16392;
  localparam int unsigned L2_BIAS_BASE   = 16416;
  localparam int unsigned ACT_OUT_BASE   = 16424;

endpackage

// File: rtl/bram_vector_writer.sv
// Snapshots a packed vector and streams it into BRAM one element per granted
// cycle, starting at BASE_ADDR. Drives the BRAM port directly so the top level
// can mux it with the loaders onto one shared BRAM.
module bram_vector_writer
  import bram_vector_writer_pkg::*;
#(
  parameter int IN_SIZE       = 1,
  parameter int OUT_SIZE      = 8,
  parameter int W             = BRAM_DATA_W,
  parameter int TOTAL_WEIGHTS = IN_SIZE * OUT_SIZE,
  parameter int ADDR_WIDTH    = 15,
  parameter int BASE_ADDR     = ACT_OUT_BASE
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [TOTAL_WEIGHTS*W-1:0] data_in,
  input  logic                       grant,
  output logic                       bram_en,
  output logic                       bram_wen,
  output logic [ADDR_WIDTH-1:0]      bram_addr,
  output logic [W-1:0]               bram_din,
  output logic                       busy,
  output logic                       done
);

  localparam int IDX_W = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(TOTAL_WEIGHTS - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);

  logic [1:0]                 state_q,  state_d;
  logic [IDX_W-1:0]           idx_q,    idx_d;
  logic [TOTAL_WEIGHTS*W-1:0] shadow_q, shadow_d;
  logic                       en_q,     en_d;
  logic                       wen_q,    wen_d;
  logic [ADDR_WIDTH-1:0]      addr_q,   addr_d;
  logic [W-1:0]               din_q,    din_d;
  logic                       done_q,   done_d;
  logic [W-1:0]               elem;

  // Select shadow element idx_q; compare-based mux keeps the index width clean.
  always_comb begin
    elem = '0;
    for (int unsigned i = 0; i < TOTAL_WEIGHTS; i++) begin
      if (idx_q == IDX_W'(i)) elem = shadow_q[i*W +: W];
    end
  end

  // Next-state and registered-output logic for IDLE -> WRITE -> DONE.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    en_d     = 1'b0;
    wen_d    = 1'b0;
    addr_d   = addr_q;
    din_d    = din_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d = data_in;
          idx_d    = '0;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (grant) begin
          en_d   = 1'b1;
          wen_d  = 1'b1;
          addr_d = BASE_A + idx_q[ADDR_WIDTH-1:0];
          din_d  = elem;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      en_q     <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      en_q     <= en_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      done_q   <= done_d;
    end
  end

  assign bram_en   = en_q;
  assign bram_wen  = wen_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
